// File: rtl/uart_tx_monitor.sv
// Receive-side monitor for a UART line: synchronises rx, decodes 8N1 frames,
// and queues good bytes in a first-word-fall-through FIFO with sticky error flags.
module uart_tx_monitor #(
  parameter int CLKS_PER_BIT    = 868,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic        rd_en,
  output logic [7:0]  rd_data,
  output logic        empty,
  output logic        full,
  output logic        frame_err,
  output logic        overflow,
  output logic [31:0] byte_cnt
);

  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int AW    = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << AW;
  localparam logic [CW-1:0] LP_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LP_FULL = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  logic          r_sync1;
  logic          r_sync2;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_frame_err;
  logic          r_overflow;
  logic [31:0]   r_byte_cnt;
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic [7:0]    r_mem [DEPTH];

  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [2:0]    w_idx_nxt;
  logic [7:0]    w_shift_nxt;
  logic          w_done;
  logic          w_stop_err;
  logic          w_rx_s;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;

  assign w_rx_s  = r_sync2;
  assign empty   = (r_wptr == r_rptr);
  assign full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign rd_data = r_mem[r_rptr[AW-1:0]];
  assign frame_err = r_frame_err;
  assign overflow  = r_overflow;
  assign byte_cnt  = r_byte_cnt;

  // A pop alongside a completed frame frees the slot, so a full FIFO still accepts it.
  assign w_pop  = rd_en && !empty;
  assign w_push = w_done && (!full || w_pop);
  assign w_drop = w_done && full && !w_pop;

  // Frame decoder next-state logic; the bit counter only decrements while nonzero.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_done      = 1'b0;
    w_stop_err  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rx_s) begin
          w_cnt_nxt   = LP_HALF;
          w_state_nxt = S_START;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        if (r_cnt != {CW{1'b0}}) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end else if (!w_rx_s) begin
          w_cnt_nxt   = LP_FULL;
          w_idx_nxt   = 3'd0;
          w_state_nxt = S_DATA;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DATA: begin
        if (r_cnt != {CW{1'b0}}) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end else begin
          w_shift_nxt = {w_rx_s, r_shift[7:1]};
          w_cnt_nxt   = LP_FULL;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (r_cnt != {CW{1'b0}}) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end else if (w_rx_s) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_stop_err  = 1'b1;
          w_state_nxt = S_BREAK;
        end
      end
      S_BREAK: begin
        if (w_rx_s) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_BREAK;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Synchroniser, decoder state, flags, counter and FIFO pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_state     <= S_IDLE;
      r_cnt       <= {CW{1'b0}};
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'd0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
      r_byte_cnt  <= 32'd0;
      r_wptr      <= {(AW+1){1'b0}};
      r_rptr      <= {(AW+1){1'b0}};
    end else begin
      r_sync1     <= rx;
      r_sync2     <= r_sync1;
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bit_idx   <= w_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_frame_err <= r_frame_err | w_stop_err;
      r_overflow  <= r_overflow | w_drop;
      r_byte_cnt  <= w_done ? (r_byte_cnt + 32'd1) : r_byte_cnt;
      r_wptr      <= w_push ? (r_wptr + {{AW{1'b0}}, 1'b1}) : r_wptr;
      r_rptr      <= w_pop  ? (r_rptr + {{AW{1'b0}}, 1'b1}) : r_rptr;
    end
  end

  // FIFO storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wptr[AW-1:0]] <= r_shift;
    end
  end

endmodule

// File: tb/tb_uart_tx_monitor.sv
// Scoreboard bench: stimulus queues expected bytes, a negedge monitor checks every accepted pop.
module tb_uart_tx_monitor;

  logic        clk;
  logic        rst;
  logic        rx;
  logic        rd_en;
  logic [7:0]  rd_data;
  logic        empty;
  logic        full;
  logic        frame_err;
  logic        overflow;
  logic [31:0] byte_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  uart_tx_monitor #(.CLKS_PER_BIT(4), .FIFO_DEPTH_LOG2(2)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rd_en(rd_en), .rd_data(rd_data),
    .empty(empty), .full(full), .frame_err(frame_err), .overflow(overflow),
    .byte_cnt(byte_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop must match the oldest expected byte.
  always @(negedge clk) begin
    if (!rst && rd_en && !empty) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got 0x%0h expected no byte", rd_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          n_fail++;
          $display("FAIL pop_data: got 0x%0h expected 0x%0h", rd_data, e);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    exp_q.delete();
  endtask

  // One full frame plus 4 idle cycles; optional pop lands on the frame-completion edge.
  task automatic send(input logic [7:0] b, input logic stop, input logic pop_at_done);
    rx = 1'b0;
    tick(4);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(4);
    end
    rx = stop;
    tick(4);
    rx = 1'b1;
    if (pop_at_done) begin
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
      tick(3);
    end else begin
      tick(4);
    end
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rx = 1'b1;
    rd_en = 1'b0;
    tick(3);
    rst = 1'b0;
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_byte_cnt", byte_cnt, 32'd0);

    // Single good byte, then an ignored pop on empty
    exp_q.push_back(8'h41);
    send(8'h41, 1'b1, 1'b0);
    check("b41_empty", {31'd0, empty}, 32'd0);
    check("b41_cnt", byte_cnt, 32'd1);
    pop();
    check("b41_empty_after_pop", {31'd0, empty}, 32'd1);
    pop();
    check("pop_on_empty", {31'd0, empty}, 32'd1);

    // One-cycle low glitch in idle
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    tick(10);
    check("glitch_empty", {31'd0, empty}, 32'd1);
    check("glitch_ferr", {31'd0, frame_err}, 32'd0);
    check("glitch_cnt", byte_cnt, 32'd1);

    // Bad stop bit, then a good byte
    do_reset();
    send(8'h55, 1'b0, 1'b0);
    check("ferr_flag", {31'd0, frame_err}, 32'd1);
    check("ferr_empty", {31'd0, empty}, 32'd1);
    check("ferr_cnt", byte_cnt, 32'd0);
    exp_q.push_back(8'hA5);
    send(8'hA5, 1'b1, 1'b0);
    check("a5_empty", {31'd0, empty}, 32'd0);
    pop();
    check("ferr_sticky", {31'd0, frame_err}, 32'd1);
    check("a5_cnt", byte_cnt, 32'd1);

    // Overfill a 4-deep FIFO
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(8'(i));
      send(8'(i), 1'b1, 1'b0);
    end
    check("ovf_full4", {31'd0, full}, 32'd1);
    check("ovf_flag_before", {31'd0, overflow}, 32'd0);
    send(8'h05, 1'b1, 1'b0);
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    check("ovf_cnt", byte_cnt, 32'd5);
    check("ovf_full5", {31'd0, full}, 32'd1);
    for (int i = 0; i < 4; i++) pop();
    check("ovf_drained", {31'd0, empty}, 32'd1);

    // Frame completes on the same edge as a pop while full
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(8'(i));
      send(8'(i), 1'b1, 1'b0);
    end
    exp_q.push_back(8'h99);
    send(8'h99, 1'b1, 1'b1);
    check("simul_overflow", {31'd0, overflow}, 32'd0);
    check("simul_full", {31'd0, full}, 32'd1);
    check("simul_cnt", byte_cnt, 32'd5);
    for (int i = 0; i < 4; i++) pop();
    check("simul_drained", {31'd0, empty}, 32'd1);

    // Reset during data bit 3 of 0xFF
    do_reset();
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(14);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(8);
    check("abort_empty", {31'd0, empty}, 32'd1);
    check("abort_cnt", byte_cnt, 32'd0);
    check("abort_ferr", {31'd0, frame_err}, 32'd0);
    exp_q.push_back(8'h3C);
    send(8'h3C, 1'b1, 1'b0);
    check("b3c_cnt", byte_cnt, 32'd1);
    pop();

    check("sb_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_monitor.md
UART_TX_MONITOR -- requirements
Module: uart_tx_monitor

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per serial bit (100 MHz / 115200); legal range is 4 or more.
REQ-002 The block SHALL have parameter FIFO_DEPTH_LOG2, default 4, giving a receive FIFO of 2^FIFO_DEPTH_LOG2 bytes.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port rx, input, 1 bit: serial line driven by riscv_top Tx; asynchronous to clk; idles high.
REQ-006 The block SHALL have port rd_en, input, 1 bit: pop request for the FIFO head.
REQ-007 The block SHALL have port rd_data, output, 8 bits: FIFO head byte (first-word-fall-through); valid only while empty=0.
REQ-008 The block SHALL have port empty, output, 1 bit: FIFO holds zero bytes.
REQ-009 The block SHALL have port full, output, 1 bit: FIFO holds 2^FIFO_DEPTH_LOG2 bytes.
REQ-010 The block SHALL have port frame_err, output, 1 bit: sticky flag, stop bit sampled low.
REQ-011 The block SHALL have port overflow, output, 1 bit: sticky flag, a good byte was dropped because the FIFO was full.
REQ-012 The block SHALL have port byte_cnt, output, 32 bits: count of frames with a valid stop bit, wrapping at 2^32.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer; all decoding uses the synchronized value rx_s (2-cycle latency).
REQ-014 The FSM SHALL have five states: IDLE, START, DATA, STOP, BREAK.
REQ-015 IDLE: rx_s=0 SHALL load bit counter CLKS_PER_BIT/2-1 and enter START.
REQ-016 START: at counter 0, rx_s=0 SHALL enter DATA with the counter reloaded to CLKS_PER_BIT-1 and bit index 0; rx_s=1 SHALL be treated as a glitch and return to IDLE with no flag.
REQ-017 DATA: at counter 0, rx_s SHALL be shifted into the data register LSB-first and the counter reloaded; after bit index 7 is sampled, the FSM SHALL enter STOP.
REQ-018 STOP: at counter 0, rx_s=1 SHALL complete the frame (REQ-020) and return to IDLE; rx_s=0 SHALL set frame_err, discard the byte and enter BREAK.
REQ-019 BREAK: the FSM SHALL stay until rx_s=1, then enter IDLE, so a line held low yields exactly one frame_err and no bytes.
REQ-020 Frame completion SHALL increment byte_cnt and push the byte if full=0; if full=1 with no pop in the same cycle, the byte SHALL be dropped and overflow set.
REQ-021 Push and pop in the same cycle SHALL both take effect, including when full (the byte is accepted, occupancy is unchanged) and when empty (no pop; the byte is pushed).
REQ-022 rd_en while empty=1 SHALL be ignored, with no pointer change and no flag.
REQ-023 The FIFO SHALL use read and write pointers one bit wider than the address, wrapping modulo 2^(FIFO_DEPTH_LOG2+1); empty and full are derived combinationally from the pointers.
REQ-024 A pushed byte SHALL appear on rd_data with empty=0 on the cycle after the push edge.
REQ-025 frame_err and overflow SHALL clear only on reset.
REQ-026 The bit counter SHALL use width clog2(CLKS_PER_BIT) and never underflow.

Reset
REQ-027 While rst=1 at a clock edge, the block SHALL enter IDLE, clear the pointers (empty=1, full=0), clear frame_err, overflow and byte_cnt, and set both synchronizer flops to 1.
REQ-028 rd_data SHALL be don't-care after reset; the bench checks it only when empty=0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame without a push, count or flag; a frame whose start bit begins after rst falls SHALL decode normally.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH_LOG2=2)
REQ-030 Send 0x41 with a valid stop bit -> empty=0, rd_data=0x41, byte_cnt=1; then pulse rd_en for 1 cycle -> empty=1.
REQ-031 Hold rx low for 1 cycle in IDLE -> no byte, no flag, state back in IDLE.
REQ-032 Send 0x55 with the stop bit low, then idle high -> frame_err=1, empty=1, byte_cnt=0; a following 0xA5 -> rd_data=0xA5.
REQ-033 Send 5 bytes 0x01..0x05 with no reads -> full=1 after the 4th byte, overflow=1, byte_cnt=5; popping 4 times yields 0x01..0x04, then empty=1.
REQ-034 With the FIFO full, complete a frame on the same cycle as rd_en -> overflow stays 0 and full stays 1; the new byte is read out last.
REQ-035 Assert rst during DATA bit 3 of 0xFF -> after reset, empty=1 and byte_cnt=0; a subsequent 0x3C is received correctly.
